// File: rtl/itim_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : itim_port_ctrl
// Description : Single-outstanding request/response front end for a 4K x 64
//               single-port (RW0) ITIM array. Optional byte-masked partial
//               writes via read-modify-write, enabled by the macro
//               ITIM_CTRL_PARTIAL_WRITE_EN (undefined: mask ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module itim_port_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_mask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [11:0] sram_addr,
    output logic        sram_en,
    output logic        sram_wmode,
    output logic [63:0] sram_wdata,
    input  logic [63:0] sram_rdata
);

    localparam int         c_BYTES     = 8;
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RD_DATA   = 2'd1;
`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
    localparam logic [1:0] c_RMW_MERGE = 2'd2;
`endif
    localparam logic [1:0] c_RESP      = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [11:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        w_accept;
    logic        w_partial;
    logic        w_null_write;
    logic        w_sram_en;
    logic        w_sram_wmode;
    logic [11:0] w_sram_addr;
    logic [63:0] w_sram_wdata;
    logic [63:0] w_merged;

`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
    logic [7:0]  r_mask;

    assign w_partial    = req_write && (req_mask != 8'h00) && (req_mask != 8'hFF);
    assign w_null_write = req_write && (req_mask == 8'h00);

    // Masked bytes come from the request, the rest from the word just read.
    for (genvar gi = 0; gi < c_BYTES; gi++) begin : g_merge
        assign w_merged[8*gi +: 8] = r_mask[gi] ? r_wdata[8*gi +: 8]
                                                : sram_rdata[8*gi +: 8];
    end
`else
    logic w_unused_mask;

    assign w_partial     = 1'b0;
    assign w_null_write  = 1'b0;
    assign w_merged      = r_wdata;
    assign w_unused_mask = ^req_mask;
`endif

    assign w_accept = req_valid && req_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (!req_write) begin
                        w_state_next = c_RD_DATA;
                    end
`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
                    else if (w_partial) begin
                        w_state_next = c_RMW_MERGE;
                    end
`endif
                    else begin
                        w_state_next = c_RESP;
                    end
                end
            end
            c_RD_DATA: w_state_next = c_RESP;
`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
            c_RMW_MERGE: w_state_next = c_RESP;
`endif
            c_RESP: begin
                if (resp_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output logic; idle array buses park on reset-cleared registers.
    always_comb begin
        w_sram_en    = 1'b0;
        w_sram_wmode = 1'b0;
        w_sram_addr  = r_addr;
        w_sram_wdata = r_wdata;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_sram_addr = req_addr;
                    if (!req_write || w_partial) begin
                        w_sram_en = 1'b1;
                    end else if (!w_null_write) begin
                        w_sram_en    = 1'b1;
                        w_sram_wmode = 1'b1;
                        w_sram_wdata = req_wdata;
                    end
                end
            end
`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
            c_RMW_MERGE: begin
                w_sram_en    = 1'b1;
                w_sram_wmode = 1'b1;
                w_sram_wdata = w_merged;
            end
`endif
            default: begin
                w_sram_en = 1'b0;
            end
        endcase
    end

    // Reset gates the enable combinationally so an in-flight write is dropped.
    assign sram_en    = w_sram_en && !reset;
    assign sram_wmode = w_sram_wmode;
    assign sram_addr  = w_sram_addr;
    assign sram_wdata = w_sram_wdata;
    assign req_ready  = (r_state == c_IDLE) && !reset;
    assign resp_valid = (r_state == c_RESP);
    assign resp_rdata = r_rdata;

    // Request latch and response data register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                if (req_write) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == c_RD_DATA) begin
                r_rdata <= sram_rdata;
            end
        end
    end

`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= req_mask;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_itim_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_itim_port_ctrl
// Description : Vector-table bench for itim_port_ctrl with a behavioural
//               4K x 64 array; expectations follow ITIM_CTRL_PARTIAL_WRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itim_port_ctrl;

`ifdef ITIM_CTRL_PARTIAL_WRITE_EN
    localparam bit c_PW = 1'b1;
`else
    localparam bit c_PW = 1'b0;
`endif
    localparam int c_NV = 11;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_mask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic [11:0] sram_addr;
    logic        sram_en;
    logic        sram_wmode;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;

    logic [63:0] mem [0:4095];
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs [c_NV];

    itim_port_ctrl u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    // Array model: read data appears the cycle after the enabled edge.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                mem[sram_addr] <= sram_wdata;
                n_wr++;
            end else begin
                sram_rdata <= mem[sram_addr];
                n_rd++;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic wr, input logic [11:0] a,
                                input logic [63:0] d, input logic [7:0] m,
                                input logic [63:0] er, input int el, input int erd,
                                input int ewr);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.wdata = d; v.mask = m;
        v.exp_rdata = er; v.exp_lat = el; v.exp_rd = erd; v.exp_wr = ewr;
        return v;
    endfunction

    // Offers one request and returns #1 after the accepting edge.
    task automatic issue_req(input logic wr, input logic [11:0] a, input logic [63:0] d,
                             input logic [7:0] m, output logic ok);
        int g;
        ok = 1'b1;
        g  = 0;
        @(posedge clock); #1;
        req_write = wr; req_addr = a; req_wdata = d; req_mask = m; req_valid = 1'b1;
        while (!req_ready && g < 20) begin
            @(posedge clock); #1;
            g++;
        end
        if (!req_ready) ok = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic wr, input logic [11:0] a, input logic [63:0] d,
                          input logic [7:0] m, output int lat, output logic [63:0] rdata,
                          output logic bad);
        logic ok;
        resp_ready = 1'b1;
        issue_req(wr, a, d, m, ok);
        bad = !ok;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (req_ready) bad = 1'b1;
            @(posedge clock); #1;
            lat++;
        end
        if (!resp_valid || req_ready) bad = 1'b1;
        rdata = resp_rdata;
        @(posedge clock); #1;
        if (resp_valid || !req_ready) bad = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          rd0;
        int          wr0;
        int          g;
        logic [63:0] rdata;
        logic [63:0] snap;
        logic        bad;
        logic        ok;

        vecs[0]  = mk("wr_full_005", 1'b1, 12'h005, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1, 0, 1);
        vecs[1]  = mk("rd_005", 1'b0, 12'h005, 64'h0, 8'h00, 64'h0123456789ABCDEF, 2, 1, 0);
        vecs[2]  = mk("wr_full_fff", 1'b1, 12'hFFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1, 0, 1);
        vecs[3]  = mk("wr_part_fff", 1'b1, 12'hFFF, 64'h0, 8'h0F, 64'h0, c_PW ? 2 : 1,
                      c_PW ? 1 : 0, 1);
        vecs[4]  = mk("rd_fff", 1'b0, 12'hFFF, 64'h0, 8'h00,
                      c_PW ? 64'hFFFFFFFF00000000 : 64'h0, 2, 1, 0);
        vecs[5]  = mk("wr_full_010", 1'b1, 12'h010, 64'h00000000AAAAAAAA, 8'hFF, 64'h0, 1, 0, 1);
        vecs[6]  = mk("wr_null_010", 1'b1, 12'h010, 64'h5555555555555555, 8'h00, 64'h0, 1, 0,
                      c_PW ? 0 : 1);
        vecs[7]  = mk("rd_010", 1'b0, 12'h010, 64'h0, 8'h00,
                      c_PW ? 64'h00000000AAAAAAAA : 64'h5555555555555555, 2, 1, 0);
        vecs[8]  = mk("wr_full_020", 1'b1, 12'h020, 64'h0, 8'hFF, 64'h0, 1, 0, 1);
        vecs[9]  = mk("wr_part_020", 1'b1, 12'h020, 64'h1122334455667788, 8'h81, 64'h0,
                      c_PW ? 2 : 1, c_PW ? 1 : 0, 1);
        vecs[10] = mk("rd_020", 1'b0, 12'h020, 64'h0, 8'h00,
                      c_PW ? 64'h1100000000000088 : 64'h1122334455667788, 2, 1, 0);

        // Reset state, with a request already offered
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h005;
        req_wdata = '0; req_mask = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'h0);
        check("rst_sram_en", 64'(sram_en), 64'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_release_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < c_NV; i++) begin
            rd0 = n_rd;
            wr0 = n_wr;
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask, lat, rdata, bad);
            check($sformatf("%s_lat", vecs[i].name), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("%s_rdata", vecs[i].name), rdata, vecs[i].exp_rdata);
            check($sformatf("%s_nrd", vecs[i].name), 64'(n_rd - rd0), 64'(vecs[i].exp_rd));
            check($sformatf("%s_nwr", vecs[i].name), 64'(n_wr - wr0), 64'(vecs[i].exp_wr));
            check($sformatf("%s_handshake", vecs[i].name), 64'(bad), 64'd0);
        end

        // Response back-pressure: hold resp_ready low for 5 cycles
        resp_ready = 1'b0;
        issue_req(1'b0, 12'h005, 64'h0, 8'h00, ok);
        check("bp_accept", 64'(ok), 64'd1);
        g = 0;
        while (!resp_valid && g < 20) begin
            @(posedge clock); #1;
            g++;
        end
        snap = resp_rdata;
        check("bp_rdata", snap, 64'h0123456789ABCDEF);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check($sformatf("bp_valid_%0d", k), 64'(resp_valid), 64'd1);
            check($sformatf("bp_stable_%0d", k), resp_rdata, 64'h0123456789ABCDEF);
            check($sformatf("bp_ready_%0d", k), 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_valid", 64'(resp_valid), 64'd0);
        check("bp_release_idle", 64'(req_ready), 64'd1);

        // Reset one cycle after accepting a partial write (a read without the option)
        do_txn(1'b1, 12'h030, 64'h0F0F0F0F0F0F0F0F, 8'hFF, lat, rdata, bad);
        check("mid_preload", 64'(bad), 64'd0);
        wr0 = n_wr;
        issue_req(c_PW, 12'h030, 64'h0, 8'h3C, ok);
        check("mid_accept", 64'(ok), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_sram_en", 64'(sram_en), 64'd0);
        check("mid_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_req_ready", 64'(req_ready), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_release_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #1;
        check("mid_no_resp", 64'(resp_valid), 64'd0);
        check("mid_no_write", 64'(n_wr - wr0), 64'd0);
        do_txn(1'b0, 12'h030, 64'h0, 8'h00, lat, rdata, bad);
        check("mid_word_kept", rdata, 64'h0F0F0F0F0F0F0F0F);
        check("mid_read_handshake", 64'(bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/itim_port_ctrl.md
ITIM_PORT_CTRL -- requirements
Module: itim_port_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  request accepted when high with req_valid.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  12  word address.
REQ-008 req_wdata  input  64  write data.
REQ-009 req_mask  input  8  byte write enable; bit i covers wdata[8i+7:8i].
REQ-010 resp_valid  output  1  response offered.
REQ-011 resp_ready  input  1  response taken when high with resp_valid.
REQ-012 resp_rdata  output  64  read data; 0 for write acks.
REQ-013 sram_addr  output  12  array RW0 address.
REQ-014 sram_en  output  1  array RW0 enable.
REQ-015 sram_wmode  output  1  array RW0 write mode (1 = write).
REQ-016 sram_wdata  output  64  array RW0 write data.
REQ-017 sram_rdata  input  64  array RW0 read data, valid the cycle after a read-enable edge.

Function
REQ-018 States SHALL be IDLE, RD_DATA, RMW_MERGE and RESP; only one request is outstanding at a time.
REQ-019 req_ready SHALL be 1 only in IDLE with reset deasserted.
REQ-020 Read accepted in IDLE: sram_en=1, sram_wmode=0, sram_addr=req_addr combinationally in the accept cycle; next state RD_DATA.
REQ-021 RD_DATA: capture sram_rdata into the response register; next state RESP; resp_valid rises 2 cycles after accept.
REQ-022 Write with req_mask=0xFF: sram_en=1, sram_wmode=1, sram_wdata=req_wdata in the accept cycle; next state RESP with resp_rdata=0; ack 1 cycle after accept.
REQ-023 Write with mask 0x00: no array access (sram_en=0); next state RESP with ack 1 cycle after accept.
REQ-024 Partial write (mask neither 0x00 nor 0xFF): read the address in the accept cycle; latch addr, wdata and mask; next state RMW_MERGE.
REQ-025 RMW_MERGE: drive a write to the latched address with per-byte merge (mask bit 1 -> latched byte, 0 -> sram_rdata byte); next state RESP; ack 2 cycles after accept.
REQ-026 RESP: resp_valid=1 and resp_rdata stable until resp_ready=1; on that handshake clear resp_valid and return to IDLE.
REQ-027 sram_en SHALL be 0 in every cycle not listed in REQ-020 to REQ-025, including RESP and IDLE without req_valid.
REQ-028 sram_addr, sram_wdata and sram_wmode are don't-care when sram_en=0 but SHALL be X-free.

Reset
REQ-029 Asserting reset at any time, including mid-RMW, SHALL immediately force state IDLE, sram_en=0, resp_valid=0, resp_rdata=0, req_ready=0.
REQ-030 An operation interrupted by reset SHALL be discarded: no write issued, no response produced.
REQ-031 req_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-032 Macro ITIM_CTRL_PARTIAL_WRITE_EN defined: REQ-023 to REQ-025 apply.
REQ-033 Macro undefined: req_mask is ignored; every write follows REQ-022; RMW_MERGE is absent.

Verification
REQ-034 Write 0x0123456789ABCDEF to addr 0x005 with mask 0xFF, then read 0x005 -> ack 1 cycle after accept; read resp_rdata=0x0123456789ABCDEF 2 cycles after accept.
REQ-035 With the macro: preload 0xFFFFFFFFFFFFFFFF at 0xFFF, write 0 with mask 0x0F, then read -> one read then one write on the array; final read 0xFFFFFFFF00000000.
REQ-036 Mask 0x00 write to 0x010 -> sram_en stays 0; ack after 1 cycle; stored data unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles after a read -> resp_valid and resp_rdata stable; req_ready=0 throughout; IDLE the cycle after resp_ready=1.
REQ-038 Assert reset in RMW_MERGE -> sram_en=0 immediately; no response; target word unchanged; req_ready=1 the cycle after reset deasserts.
